// File: rtl/state2serial_tx.sv
// Framed, bit-timed serial transmitter for the neuron-bank state word (LSB first).
// Optional even-parity bit between data and stop: define STATE2SERIAL_PARITY_EN.
module state2serial_tx #(
  parameter int unsigned N   = 15,
  parameter int unsigned DIV = 4
) (
  input  logic         clk,
  input  logic         re,
  input  logic         start,
  input  logic [N-1:0] state_in,
  output logic         data_out,
  output logic         frame_out,
  output logic         busy,
  output logic         done
);

  localparam int unsigned TW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

`ifdef STATE2SERIAL_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t         state, state_n;
  logic [TW-1:0]  timer, timer_n;
  logic [IW-1:0]  idx, idx_n;
  logic [N-1:0]   shreg, shreg_n;
  logic           done_n, data_n, frame_n;
  logic           bit_end;
`ifdef STATE2SERIAL_PARITY_EN
  logic           par, par_n;
`endif

  // State register; outputs are registered from the next-state values
  always_ff @(posedge clk) begin
    if (!re) begin
      state     <= IDLE;
      timer     <= '0;
      idx       <= '0;
      shreg     <= '0;
      data_out  <= 1'b1;
      frame_out <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef STATE2SERIAL_PARITY_EN
      par       <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      timer     <= timer_n;
      idx       <= idx_n;
      shreg     <= shreg_n;
      data_out  <= data_n;
      frame_out <= frame_n;
      busy      <= frame_n;
      done      <= done_n;
`ifdef STATE2SERIAL_PARITY_EN
      par       <= par_n;
`endif
    end
  end

  // Next-state, counters and next output values
  always_comb begin
    state_n = state;
    timer_n = timer;
    idx_n   = idx;
    shreg_n = shreg;
    done_n  = 1'b0;
    data_n  = 1'b1;
`ifdef STATE2SERIAL_PARITY_EN
    par_n   = par;
`endif
    bit_end = (timer == TW'(DIV - 1));

    if (state == IDLE) begin
      if (start) begin
        state_n = START;
        shreg_n = state_in;
        timer_n = '0;
        idx_n   = '0;
`ifdef STATE2SERIAL_PARITY_EN
        par_n   = ^state_in;
`endif
      end
    end else begin
      timer_n = bit_end ? '0 : timer + TW'(1);
    end

    case (state)
      START: if (bit_end) state_n = DATA;
      DATA: begin
        if (bit_end) begin
          shreg_n = shreg >> 1;
          if (idx == IW'(N - 1)) begin
            idx_n = '0;
`ifdef STATE2SERIAL_PARITY_EN
            state_n = PAR;
`else
            state_n = STOP;
`endif
          end else begin
            idx_n = idx + IW'(1);
          end
        end
      end
`ifdef STATE2SERIAL_PARITY_EN
      PAR: if (bit_end) state_n = STOP;
`endif
      STOP: begin
        if (bit_end) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end
      end
      default: ;
    endcase

    case (state_n)
      START:   data_n = 1'b0;
      DATA:    data_n = shreg_n[0];
`ifdef STATE2SERIAL_PARITY_EN
      PAR:     data_n = par_n;
`endif
      default: data_n = 1'b1;
    endcase
    frame_n = (state_n != IDLE);
  end

endmodule

// File: tb/tb_state2serial_tx.sv
// Directed self-checking bench for state2serial_tx: a DIV=4 instance for framing,
// reset and busy behaviour, and a DIV=1 instance for back-to-back frames.
module tb_state2serial_tx;

  localparam int N = 15;
`ifdef STATE2SERIAL_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int NB = N + 2 + P;   // bits per frame
  localparam int F4 = NB * 4;      // frame cycles at DIV=4
  localparam int PER1 = NB + 1;    // back-to-back period at DIV=1

  logic clk, re;
  logic start, start1;
  logic [N-1:0] state_in, state_in1;
  logic data_out, frame_out, busy, done;
  logic data_out1, frame_out1, busy1, done1;

  int checks = 0;
  int passes = 0;

  state2serial_tx #(.N(N), .DIV(4)) dut (
    .clk(clk), .re(re), .start(start), .state_in(state_in),
    .data_out(data_out), .frame_out(frame_out), .busy(busy), .done(done)
  );

  state2serial_tx #(.N(N), .DIV(1)) dut1 (
    .clk(clk), .re(re), .start(start1), .state_in(state_in1),
    .data_out(data_out1), .frame_out(frame_out1), .busy(busy1), .done(done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed {data,frame,busy,done}=%b expected %b", tag, obs, exp);
  endtask

  // Expected line value for frame bit b of word w
  function automatic logic exp_bit(input logic [N-1:0] w, input int b);
    if (b == 0) return 1'b0;
    if (b <= N) return w[b-1];
    if (P == 1 && b == N + 1) return ^w;
    return 1'b1;
  endfunction

  // One DIV=4 frame; optionally re-pulse start and change state_in mid-DATA
  task automatic run_frame(input string name, input logic [N-1:0] w, input bit disturb);
    state_in = w;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < F4; i++) begin
      chk($sformatf("%s c%0d", name, i), {data_out, frame_out, busy, done},
          {exp_bit(w, i / 4), 3'b110});
      if (disturb && i == 30) begin
        start = 1'b1;
        state_in = 15'h7FFF;
      end
      if (disturb && i == 31) start = 1'b0;
      step();
    end
    chk($sformatf("%s done", name), {data_out, frame_out, busy, done}, 4'b1001);
    for (int i = 0; i < 8; i++) begin
      step();
      chk($sformatf("%s idle%0d", name, i), {data_out, frame_out, busy, done}, 4'b1000);
    end
  endtask

  initial begin
    re = 1'b0;
    start = 1'b0;
    start1 = 1'b0;
    state_in = '0;
    state_in1 = 15'h2B5D;

    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("reset%0d", i), {data_out, frame_out, busy, done}, 4'b1000);
      chk($sformatf("reset1_%0d", i), {data_out1, frame_out1, busy1, done1}, 4'b1000);
    end
    re = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      chk($sformatf("idle%0d", i), {data_out, frame_out, busy, done}, 4'b1000);
      chk($sformatf("idle1_%0d", i), {data_out1, frame_out1, busy1, done1}, 4'b1000);
    end

    run_frame("basic5A3C", 15'h5A3C, 1'b0);
    run_frame("par0001", 15'h0001, 1'b0);
    run_frame("busyign", 15'h1357, 1'b1);

    // Back-to-back frames on the DIV=1 instance
    start1 = 1'b1;
    step();
    for (int j = 0; j < 3 * PER1; j++) begin
      if ((j % PER1) < NB)
        chk($sformatf("b2b c%0d", j), {data_out1, frame_out1, busy1, done1},
            {exp_bit(state_in1, j % PER1), 3'b110});
      else
        chk($sformatf("b2b done c%0d", j), {data_out1, frame_out1, busy1, done1}, 4'b1001);
      if (j == 3 * PER1 - 1) start1 = 1'b0;
      step();
    end
    chk("b2b stop", {data_out1, frame_out1, busy1, done1}, 4'b1000);

    // Reset pulse during DATA bit 7 (frame bit 8)
    state_in = 15'h5A3C;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i <= 33; i++) begin
      chk($sformatf("prerst c%0d", i), {data_out, frame_out, busy, done},
          {exp_bit(15'h5A3C, i / 4), 3'b110});
      if (i < 33) step();
    end
    re = 1'b0;
    step();
    re = 1'b1;
    chk("midrst", {data_out, frame_out, busy, done}, 4'b1000);
    for (int i = 0; i < F4; i++) begin
      step();
      chk($sformatf("postrst%0d", i), {data_out, frame_out, busy, done}, 4'b1000);
    end
    run_frame("after_rst", 15'h4C21, 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
